// File: rtl/cache_controller_if.sv
// Bus bundle for cache_controller: MEM-stage request, data-cache port and SRAM-controller port.
// master = controller side, slave = surrounding pipeline/cache/SRAM side.
interface cache_controller_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  logic [18:0] cache_address;
  logic [63:0] cache_write_data;
  logic        cache_read;
  logic        cache_write;
  logic        mem_write;
  logic        cache_hit;
  logic [31:0] cache_read_data;

  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read;
  logic        sram_write;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  modport master (
    input  MEM_R_EN, MEM_W_EN, address, wdata,
    output rdata, ready,
    output cache_address, cache_write_data, cache_read, cache_write, mem_write,
    input  cache_hit, cache_read_data,
    output sram_address, sram_wdata, sram_read, sram_write,
    input  sram_rdata, sram_ready
  );

  modport slave (
    output MEM_R_EN, MEM_W_EN, address, wdata,
    input  rdata, ready,
    input  cache_address, cache_write_data, cache_read, cache_write, mem_write,
    output cache_hit, cache_read_data,
    input  sram_address, sram_wdata, sram_read, sram_write,
    output sram_rdata, sram_ready
  );
endinterface

// File: rtl/cache_controller.sv
// Write-through, read-allocate controller between MEM stage, 2-way data cache and SRAM controller.
// Optional hit/miss counters when CACHE_STATS_EN is defined.
module cache_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CACHE_STATS_EN
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count,
`endif
  cache_controller_if.master   bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL_LO = 2'd1;
  localparam logic [1:0] S_FILL_HI = 2'd2;
  localparam logic [1:0] S_WRITE   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] lo_word_q, lo_word_d;
  logic [31:0] eff;

  assign eff = bus.address - BASE_ADDR;

  always_comb begin
    state_d              = state_q;
    lo_word_d            = lo_word_q;
    bus.ready            = 1'b1;
    bus.rdata            = '0;
    bus.cache_address    = eff[18:0];
    bus.cache_write_data = '0;
    bus.cache_read       = 1'b0;
    bus.cache_write      = 1'b0;
    bus.mem_write        = 1'b0;
    bus.sram_address     = '0;
    bus.sram_wdata       = '0;
    bus.sram_read        = 1'b0;
    bus.sram_write       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A simultaneous load+store request takes the store path.
        if (bus.MEM_W_EN) begin
          bus.mem_write = 1'b1;
          bus.ready     = 1'b0;
          state_d       = S_WRITE;
        end else if (bus.MEM_R_EN) begin
          bus.cache_read = 1'b1;
          if (bus.cache_hit) begin
            bus.rdata = bus.cache_read_data;
          end else begin
            bus.ready = 1'b0;
            state_d   = S_FILL_LO;
          end
        end
      end
      S_FILL_LO: begin
        bus.ready        = 1'b0;
        bus.sram_read    = 1'b1;
        bus.sram_address = {eff[31:3], 3'b000};
        if (bus.sram_ready) begin
          lo_word_d = bus.sram_rdata;
          state_d   = S_FILL_HI;
        end
      end
      S_FILL_HI: begin
        bus.ready        = 1'b0;
        bus.sram_read    = 1'b1;
        bus.sram_address = {eff[31:3], 3'b100};
        if (bus.sram_ready) begin
          bus.cache_write      = 1'b1;
          bus.cache_write_data = {bus.sram_rdata, lo_word_q};
          bus.rdata            = eff[2] ? bus.sram_rdata : lo_word_q;
          bus.ready            = 1'b1;
          state_d              = S_IDLE;
        end
      end
      S_WRITE: begin
        bus.ready        = 1'b0;
        bus.sram_write   = 1'b1;
        bus.sram_address = eff;
        bus.sram_wdata   = bus.wdata;
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lo_word_q <= '0;
    end else begin
      state_q   <= state_d;
      lo_word_q <= lo_word_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;
  logic        hit_evt, miss_evt;

  assign hit_evt  = (state_q == S_IDLE) && bus.MEM_R_EN && !bus.MEM_W_EN && bus.cache_hit;
  assign miss_evt = (state_q == S_IDLE) && bus.MEM_R_EN && !bus.MEM_W_EN && !bus.cache_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit_evt && (hit_count_q != '1))
        hit_count_q <= hit_count_q + 32'd1;
      if (miss_evt && (miss_count_q != '1))
        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
